// File: rtl/pi_shift_regs.sv
// Pi-side serial register port: synchronises the Pi's serial clock, data, latch and select
// into clk, deserialises RD/RC writes and serialises TD/TC back on r_dout.
module pi_shift_regs #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r_clk,
  input  logic             r_din,
  input  logic             r_le,
  input  logic [1:0]       r_sel,
  input  logic [WIDTH-1:0] td,
  input  logic [WIDTH-1:0] tc,
  output logic             r_dout,
  output logic [WIDTH-1:0] rd,
  output logic [WIDTH-1:0] rc,
  output logic             rd_strobe,
  output logic             rc_strobe,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  logic [SYNC_STAGES-1:0]      clk_sync, din_sync, le_sync;
  logic [SYNC_STAGES-1:0][1:0] sel_sync;
  logic                        clk_prev, le_prev;
  logic                        clk_s, din_s, le_s;
  logic [1:0]                  sel_s;
  logic                        clk_rise, le_rise;

  state_t                      state;
  logic [CW-1:0]               count;
  logic [WIDTH-1:0]            in_sr, out_sr;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign le_s     = le_sync[SYNC_STAGES-1];
  assign sel_s    = sel_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign le_rise  = le_s & ~le_prev;
  assign r_dout   = out_sr[WIDTH-1];

  // Every synchroniser stage and edge register is in the reset domain, so no stale
  // pin history can fake an edge right after reset_n deasserts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '0;
      din_sync <= '0;
      le_sync  <= '0;
      sel_sync <= '0;
      clk_prev <= 1'b0;
      le_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old
      // value, which is what turns this into a real multi-flop chain.
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], r_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], r_din};
      le_sync  <= {le_sync[SYNC_STAGES-2:0], r_le};
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], r_sel};
      clk_prev <= clk_s;
      le_prev  <= le_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      in_sr     <= '0;
      out_sr    <= '0;
      rd        <= '0;
      rc        <= '0;
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      rc_strobe <= 1'b0;
      frame_err <= 1'b0;
      // A latch rise ends the frame and swallows any r_clk rise seen in the same cycle.
      if (le_rise) begin
        state <= IDLE;
        count <= '0;
        if (sel_s[1]) begin
          if (state == FULL) begin
            if (sel_s[0]) begin
              rc        <= in_sr;
              rc_strobe <= 1'b1;
            end else begin
              rd        <= in_sr;
              rd_strobe <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          out_sr <= sel_s[0] ? tc : td;
        end
      end else if (clk_rise) begin
        if (sel_s[1]) begin
          in_sr <= {in_sr[WIDTH-2:0], din_s};
          if (count != FULL_COUNT) count <= count + 1'b1;
          state <= (state == FULL || count == FULL_COUNT - 1'b1) ? FULL : SHIFT;
        end else begin
          out_sr <= {out_sr[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_shift_regs.sv
// Directed bench for pi_shift_regs: drives Pi pins slowly relative to clk and checks
// register commits, latency, frame errors, readback bit order and reset behaviour.
module tb_pi_shift_regs;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       r_clk, r_din, r_le;
  logic [1:0] r_sel;
  logic [7:0] td, tc;
  logic       r_dout;
  logic [7:0] rd, rc;
  logic       rd_strobe, rc_strobe, frame_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd_h [6];
  logic [7:0] rc_h [6];
  logic       rds_h [6];
  logic       rcs_h [6];
  logic       fe_h [6];

  pi_shift_regs #(.SYNC_STAGES(2), .WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .r_clk(r_clk), .r_din(r_din), .r_le(r_le),
    .r_sel(r_sel), .td(td), .tc(tc), .r_dout(r_dout), .rd(rd), .rc(rc),
    .rd_strobe(rd_strobe), .rc_strobe(rc_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data is held well past the synchroniser depth before and after each r_clk edge.
  task automatic send_bit(input logic b);
    r_din = b;
    wait_cycles(3);
    r_clk = 1'b1;
    wait_cycles(3);
    r_clk = 1'b0;
    wait_cycles(3);
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) send_bit(v[i]);
  endtask

  // Raise r_le (optionally with r_clk) and record outputs #1 after each of the next
  // six posedges; entry 2 is the third edge, where a commit must land.
  task automatic latch_capture(input logic with_clk);
    @(negedge clk);
    r_le = 1'b1;
    if (with_clk) r_clk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      rd_h[i]  = rd;
      rc_h[i]  = rc;
      rds_h[i] = rd_strobe;
      rcs_h[i] = rc_strobe;
      fe_h[i]  = frame_err;
    end
    @(negedge clk);
    r_le  = 1'b0;
    r_clk = 1'b0;
    wait_cycles(4);
  endtask

  task automatic set_sel(input logic [1:0] s);
    @(negedge clk);
    r_sel = s;
    wait_cycles(3);
  endtask

  logic [7:0] exp_dout;

  initial begin
    reset_n = 1'b0;
    r_clk = 1'b0; r_din = 1'b0; r_le = 1'b0; r_sel = 2'b00;
    td = 8'h00; tc = 8'h00;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(2);

    check("reset_rd", rd, 8'h00);
    check("reset_rc", rc, 8'h00);
    check("reset_dout", r_dout, 1'b0);
    check("reset_rd_strobe", rd_strobe, 1'b0);
    check("reset_rc_strobe", rc_strobe, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);

    // Full RD write 0xA5 with exact latency
    set_sel(2'b10);
    send_byte(8'hA5, 8);
    latch_capture(1'b0);
    check("a5_rd_before_latency", rd_h[1], 8'h00);
    check("a5_strobe_before", rds_h[1], 1'b0);
    check("a5_rd_at_latency", rd_h[2], 8'hA5);
    check("a5_strobe_at", rds_h[2], 1'b1);
    check("a5_strobe_after", rds_h[3], 1'b0);
    check("a5_rc_unchanged", rc_h[3], 8'h00);
    check("a5_no_frame_err", fe_h[2], 1'b0);

    // Short RC frame: 7 bits
    set_sel(2'b11);
    send_byte(8'h3C, 7);
    latch_capture(1'b0);
    check("short_fe_before", fe_h[1], 1'b0);
    check("short_fe_pulse", fe_h[2], 1'b1);
    check("short_fe_after", fe_h[3], 1'b0);
    check("short_rc_strobe", rcs_h[2], 1'b0);
    check("short_rc_unchanged", rc_h[5], 8'h00);

    // Following full frame 0x3C commits to RC
    send_byte(8'h3C, 8);
    latch_capture(1'b0);
    check("rc_3c", rc_h[2], 8'h3C);
    check("rc_strobe", rcs_h[2], 1'b1);
    check("rc_no_fe", fe_h[2], 1'b0);
    check("rc_rd_kept", rd_h[5], 8'hA5);

    // TC readback, tc changed after load must not matter
    tc = 8'h3C; td = 8'h80;
    set_sel(2'b01);
    latch_capture(1'b0);
    tc = 8'hC3;
    exp_dout = 8'b0011_1100;
    check("tc_read_bit0", r_dout, exp_dout[7]);
    for (int i = 1; i < 8; i++) begin
      send_bit(1'b0);
      check($sformatf("tc_read_bit%0d", i), r_dout, exp_dout[7-i]);
    end
    check("read_rd_kept", rd, 8'hA5);

    // TD readback selects td
    set_sel(2'b00);
    latch_capture(1'b0);
    check("td_read_msb", r_dout, 1'b1);
    send_bit(1'b0);
    check("td_read_shift", r_dout, 1'b0);

    // Overrun: 10 bits keeps last 8
    set_sel(2'b10);
    send_bit(1'b1); send_bit(1'b1);
    send_byte(8'h7F, 8);
    latch_capture(1'b0);
    check("overrun_rd", rd_h[2], 8'h7F);
    check("overrun_strobe", rds_h[2], 1'b1);
    check("overrun_no_fe", fe_h[2], 1'b0);

    // 8th r_clk and r_le rise together: latch wins, frame short
    send_byte(8'h00, 7);
    r_din = 1'b0;
    wait_cycles(3);
    latch_capture(1'b1);
    check("simul_fe", fe_h[2], 1'b1);
    check("simul_no_strobe", rds_h[2], 1'b0);
    check("simul_rd_kept", rd_h[5], 8'h7F);

    // Reset mid-frame, then clean 0x81
    send_byte(8'hF0, 4);
    @(negedge clk);
    reset_n = 1'b0;
    wait_cycles(2);
    check("midreset_rd", rd, 8'h00);
    check("midreset_rc", rc, 8'h00);
    reset_n = 1'b1;
    wait_cycles(3);
    send_byte(8'h81, 8);
    latch_capture(1'b0);
    check("post_reset_rd", rd_h[2], 8'h81);
    check("post_reset_strobe", rds_h[2], 1'b1);
    check("post_reset_no_fe", fe_h[2], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
